sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one asynchronous SRAM between a writer and a reader
module sram_arbiter #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] addr,
   inout  wire  [DATA_W-1:0] sram,
   output logic              ce_n,
   output logic              we_n,
   output logic              oe_n,
   output logic              busy
);
   typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, RD_SETUP, RD_CAPTURE} state_t;
   state_t            r_state;
   logic              r_last_rd;
   logic [DATA_W-1:0] r_wdata;
   logic              w_wr_win;
   logic              w_drive;
   assign w_wr_win = wr_req && (!rd_req || r_last_rd);
   assign w_drive  = (r_state == WR_SETUP) || (r_state == WR_PULSE);
   assign sram     = w_drive ? r_wdata : {DATA_W{1'bz}};
   assign busy     = r_state != IDLE;
   // access sequencer: grants in IDLE, then walks the write or read strobe sequence with registered strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last_rd <= 1'b1;
         r_wdata   <= '0;
         addr      <= '0;
         rd_data   <= '0;
         ce_n      <= 1'b1;
         we_n      <= 1'b1;
         oe_n      <= 1'b1;
         wr_ack    <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         wr_ack   <= 1'b0;
         rd_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_wr_win) begin
                  r_state   <= WR_SETUP;
                  addr      <= wr_addr;
                  r_wdata   <= wr_data;
                  r_last_rd <= 1'b0;
                  ce_n      <= 1'b0;
               end else if (rd_req) begin
                  r_state   <= RD_SETUP;
                  addr      <= rd_addr;
                  r_last_rd <= 1'b1;
                  ce_n      <= 1'b0;
                  oe_n      <= 1'b0;
               end
            end
            WR_SETUP: begin
               r_state <= WR_PULSE;
               we_n    <= 1'b0;
               wr_ack  <= 1'b1;
            end
            WR_PULSE: begin
               r_state <= IDLE;
               ce_n    <= 1'b1;
               we_n    <= 1'b1;
            end
            RD_SETUP: r_state <= RD_CAPTURE;
            RD_CAPTURE: begin
               r_state  <= IDLE;
               ce_n     <= 1'b1;
               oe_n     <= 1'b1;
               rd_data  <= sram;
               rd_valid <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
